regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised integer register file with an integrated write-pending scoreboard for the pipelined core. It is the next generation of the core's register file. It adds:
- configurable width, depth and read-port count;
- hardwired zero register and asynchronous clear;
- optional same-cycle write-to-read bypass;
- per-register busy tracking, so decode can stall on RAW hazards without a separate hazard block.

It sits between decode (reads, issue marking) and writeback (writes, busy release).

## Interface
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (≥2; need not be a power of two).
- NREAD, 2, number of independent read ports (1–4).
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = no forwarding.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy.
- AW (localparam) = $clog2(NREGS).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- rd_addr  in  NREAD*AW  read addresses; port i uses bits [i*AW +: AW].
- rd_data  out  NREAD*XLEN  read data; port i uses bits [i*XLEN +: XLEN].
- rd_busy  out  NREAD  busy status of each addressed register.
- wr_en  in  1  writeback write strobe.
- wr_addr  in  AW  writeback destination.
- wr_data  in  XLEN  writeback data.
- iss_en  in  1  issue strobe: marks iss_addr as having a pending write.
- iss_addr  in  AW  destination of the issuing instruction.
- flush  in  1  clear all busy bits (pipeline flush).
- busy_cnt  out  AW+1  number of registers currently busy.

## Operation
- Storage: NREGS × XLEN flops, plus NREGS busy flops and an AW+1-bit busy counter.
- Reset (rst_n low, asynchronous):
  - all registers, all busy bits and busy_cnt go to 0 immediately;
  - held while rst_n is low;
  - releasing rst_n mid-operation discards any in-flight write or issue.
- Writes: on posedge with wr_en=1, regs[wr_addr] ← wr_data. Ignored when:
  - wr_addr ≥ NREGS;
  - wr_addr=0 with ZERO_REG=1.
- Reads are combinational per port:
  - addr ≥ NREGS → data 0, busy 0;
  - addr=0 with ZERO_REG=1 → data 0, busy 0;
  - BYPASS=1, wr_en=1 and wr_addr equal to rd_addr (the write is not itself ignored) → data = wr_data and busy = 0, unless iss_en targets the same address that cycle, in which case busy = 1 with data = wr_data;
  - otherwise → data = regs[addr], busy = busy[addr].
- Busy update, in order of precedence each cycle:
  1. flush=1 → all busy bits cleared; iss_en and the busy effect of wr_en are ignored that cycle. The data write still occurs.
  2. iss_en=1 and wr_en=1 to the same address → busy set. The new producer wins.
  3. Otherwise iss_en sets busy[iss_addr] and wr_en clears busy[wr_addr], independently.
  - Issue to an invalid address (≥ NREGS, or 0 with ZERO_REG) has no effect.
  - Issue to an already-busy register leaves it busy. No nesting count.
  - Write to a non-busy register leaves it clear.
- busy_cnt:
  - always equals the popcount of the busy bits;
  - registered, so it updates together with the busy bits;
  - maintained incrementally: +1 when a bit goes 0→1, −1 when a bit goes 1→0, net 0 if both happen to different registers;
  - on flush, 0.

## Timing
- Read latency: 0 cycles (combinational from rd_addr, regs, busy and the bypass inputs).
- Write visibility:
  - BYPASS=1: same cycle, via bypass;
  - BYPASS=0: the cycle after the posedge on which it is written.
- Busy set or clear is visible on rd_busy the cycle after the iss_en or wr_en edge; with BYPASS=1, a write clears rd_busy combinationally in the same cycle.
- There is no backpressure. Every strobe is accepted on the edge where it is sampled high.
- Multiple read ports may address the same register; each returns identical data and busy.

## Test plan
- Reset: write 0xDEADBEEF to r5, assert rst_n low between clock edges → rd_data for r5 = 0 and busy_cnt = 0 without waiting for an edge.
- Zero register: wr_en to r0 with 0x12345678 and iss_en to r0 → port0 reading r0 returns 0, rd_busy = 0, busy_cnt = 0.
- Bypass:
  - BYPASS=1: wr_en r7 = 0xA5A5A5A5 while both ports read r7 → both return 0xA5A5A5A5 in the same cycle.
  - BYPASS=0: the same stimulus returns the old value, and 0xA5A5A5A5 on the next cycle.
- Scoreboard:
  - iss_en r3, then iss_en r4 → busy_cnt 1 then 2, rd_busy set for r3;
  - wr_en r3 → r3 busy clears and busy_cnt = 1;
  - iss_en r4 with wr_en r4 in the same cycle → r4 stays busy and busy_cnt stays 1.
- Flush: with r3, r4 and r9 busy, assert flush with iss_en r10 and wr_en r3 = 0x55 → all busy bits 0, busy_cnt = 0, r3 reads 0x55, r10 not busy.
- Non-power-of-two depth: NREGS=24, NREAD=3 → write to r30 ignored; reads of r30 return 0 and busy 0; r23 writes and reads correctly on all three ports.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bus of the scoreboarded register file.
// Strobes have no ready: wr_en, iss_en and flush are accepted on every edge where they are high.
interface regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NREAD*AW-1:0]   rd_addr;
    logic [NREAD*XLEN-1:0] rd_data;
    logic [NREAD-1:0]      rd_busy;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [XLEN-1:0]       wr_data;
    logic                  iss_en;
    logic [AW-1:0]         iss_addr;
    logic                  flush;
    logic [AW:0]           busy_cnt;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        input  rd_data, rd_busy, busy_cnt
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        output rd_data, rd_busy, busy_cnt
    );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with per-register write-pending (busy) tracking,
// optional write-to-read bypass and a registered busy population count.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NREAD    = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input logic         clk,
    input logic         rst_n,
    regfile_sb_if.slave bus
);
    localparam int AW   = $clog2(NREGS);
    localparam int SPAN = 1 << AW;

    // addr_ok covers the whole address space so out-of-range and zero-register
    // addresses are filtered by one lookup instead of range compares.
    logic [SPAN-1:0] addr_ok;
    for (genvar g = 0; g < SPAN; g++) begin : g_ok
        assign addr_ok[g] = (g < NREGS) && !((ZERO_REG != 0) && (g == 0));
    end

    logic wr_ok;
    logic iss_ok;
    logic same_dst;

    assign wr_ok    = bus.wr_en  && addr_ok[bus.wr_addr];
    assign iss_ok   = bus.iss_en && addr_ok[bus.iss_addr];
    assign same_dst = (bus.wr_addr == bus.iss_addr);

    // ---------------- data storage ----------------
    logic [XLEN-1:0] regs [NREGS];

    for (genvar r = 0; r < NREGS; r++) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                regs[r] <= '0;
            end else if (wr_ok && (bus.wr_addr == AW'(r))) begin
                regs[r] <= bus.wr_data;
            end
        end
    end

    // ---------------- busy scoreboard ----------------
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_nxt;
    logic [SPAN-1:0]  busy_ext;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_nxt;
    logic             cnt_inc;
    logic             cnt_dec;

    assign busy_ext = SPAN'(busy_q);

    // Clear before set so a same-cycle issue to the written register keeps it busy.
    always_comb begin
        busy_nxt = busy_q;
        if (bus.flush) begin
            busy_nxt = '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr_ok && (bus.wr_addr == AW'(i))) busy_nxt[i] = 1'b0;
            end
            for (int i = 0; i < NREGS; i++) begin
                if (iss_ok && (bus.iss_addr == AW'(i))) busy_nxt[i] = 1'b1;
            end
        end
    end

    // At most one bit rises and one falls per cycle, so the count moves by -1..+1.
    always_comb begin
        cnt_inc = iss_ok && !busy_ext[bus.iss_addr];
        cnt_dec = wr_ok && busy_ext[bus.wr_addr] && !(iss_ok && same_dst);
        if (bus.flush) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt_q + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_nxt;
            cnt_q  <= cnt_nxt;
        end
    end

    assign bus.busy_cnt = cnt_q;

    // The incremental count must always agree with the busy bits it summarises.
    assert property (@(posedge clk) disable iff (!rst_n)
        cnt_q == (AW+1)'($countones(busy_q)));

    // ---------------- read ports ----------------
    for (genvar p = 0; p < NREAD; p++) begin : g_port
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] reg_val;
        logic [XLEN-1:0] rdat;
        logic            rbusy;

        assign addr = bus.rd_addr[p*AW +: AW];

        always_comb begin
            reg_val = '0;
            for (int i = 0; i < NREGS; i++) begin
                if (addr == AW'(i)) reg_val = regs[i];
            end
        end

        always_comb begin
            rdat  = '0;
            rbusy = 1'b0;
            if (!addr_ok[addr]) begin
                rdat  = '0;
                rbusy = 1'b0;
            end else if ((BYPASS != 0) && wr_ok && (bus.wr_addr == addr)) begin
                rdat  = bus.wr_data;
                rbusy = iss_ok && (bus.iss_addr == addr);
            end else begin
                rdat  = reg_val;
                rbusy = busy_ext[addr];
            end
        end

        assign bus.rd_data[p*XLEN +: XLEN] = rdat;
        assign bus.rd_busy[p]              = rbusy;
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: three instances (bypass, no bypass, 24 regs x 3 ports) share one stimulus stream.
module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        wr_en, iss_en, flush;
  logic [4:0]  wr_addr, iss_addr;
  logic [31:0] wr_data;
  logic [4:0]  ra [3];

  regfile_sb_if #(.XLEN(32), .NREGS(32), .NREAD(2)) if_a ();
  regfile_sb_if #(.XLEN(32), .NREGS(32), .NREAD(2)) if_b ();
  regfile_sb_if #(.XLEN(32), .NREGS(24), .NREAD(3)) if_c ();

  assign if_a.rd_addr = {ra[1], ra[0]};
  assign if_b.rd_addr = {ra[1], ra[0]};
  assign if_c.rd_addr = {ra[2], ra[1], ra[0]};
  assign if_a.wr_en = wr_en;     assign if_b.wr_en = wr_en;     assign if_c.wr_en = wr_en;
  assign if_a.wr_addr = wr_addr; assign if_b.wr_addr = wr_addr; assign if_c.wr_addr = wr_addr;
  assign if_a.wr_data = wr_data; assign if_b.wr_data = wr_data; assign if_c.wr_data = wr_data;
  assign if_a.iss_en = iss_en;   assign if_b.iss_en = iss_en;   assign if_c.iss_en = iss_en;
  assign if_a.iss_addr = iss_addr; assign if_b.iss_addr = iss_addr; assign if_c.iss_addr = iss_addr;
  assign if_a.flush = flush;     assign if_b.flush = flush;     assign if_c.flush = flush;

  regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a));
  regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(0), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b));
  regfile_sb #(.XLEN(32), .NREGS(24), .NREAD(3), .BYPASS(1), .ZERO_REG(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q [$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pack(input logic [95:0] d, input logic [2:0] b, input logic [5:0] c);
    return {23'b0, d, b, c};
  endfunction

  function automatic logic [127:0] act_a();
    return pack({32'b0, if_a.rd_data}, {1'b0, if_a.rd_busy}, if_a.busy_cnt);
  endfunction
  function automatic logic [127:0] act_b();
    return pack({32'b0, if_b.rd_data}, {1'b0, if_b.rd_busy}, if_b.busy_cnt);
  endfunction
  function automatic logic [127:0] act_c();
    return pack(if_c.rd_data, if_c.rd_busy, if_c.busy_cnt);
  endfunction

  // ---------------- reference model (k=0: 32 regs, k=1: 24 regs) ----------------
  logic [31:0] m_regs [2][32];
  bit          m_busy [2][32];

  function automatic bit ok(input int k, input logic [4:0] a);
    return (int'(a) < ((k == 0) ? 32 : 24)) && (a != 5'd0);
  endfunction

  function automatic int m_count(input int k);
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[k][i]);
    return n;
  endfunction

  function automatic void m_read(input int k, input bit byp, input logic [4:0] a,
                                 output logic [31:0] d, output bit b);
    if (!ok(k, a)) begin
      d = 32'd0; b = 1'b0;
    end else if (byp && wr_en && wr_addr == a) begin
      d = wr_data; b = iss_en && (iss_addr == a);
    end else begin
      d = m_regs[k][a]; b = m_busy[k][a];
    end
  endfunction

  function automatic logic [127:0] m_predict(input int k, input bit byp, input int nread);
    logic [95:0] d = '0;
    logic [2:0]  b = '0;
    logic [31:0] dd;
    bit          bb;
    for (int p = 0; p < nread; p++) begin
      m_read(k, byp, ra[p], dd, bb);
      d[p*32 +: 32] = dd;
      b[p] = bb;
    end
    return pack(d, b, 6'(m_count(k)));
  endfunction

  task automatic m_edge(input int k);
    if (wr_en && ok(k, wr_addr)) m_regs[k][wr_addr] = wr_data;
    if (flush) begin
      for (int i = 0; i < 32; i++) m_busy[k][i] = 1'b0;
    end else begin
      if (wr_en && ok(k, wr_addr)) m_busy[k][wr_addr] = 1'b0;
      if (iss_en && ok(k, iss_addr)) m_busy[k][iss_addr] = 1'b1;
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++) begin
        m_regs[k][i] = 32'd0;
        m_busy[k][i] = 1'b0;
      end
  endtask

  // ---------------- vectors and driver ----------------
  typedef struct {
    logic        we;  logic [4:0] wa; logic [31:0] wd;
    logic        ie;  logic [4:0] ia; logic        fl;
    logic [4:0]  r0;  logic [4:0] r1; logic [4:0]  r2;
    logic [31:0] a_d0; logic a_b0; logic [31:0] a_d1; logic a_b1;
    logic [31:0] b_d0; logic [5:0] cnt;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic ie, input logic [4:0] ia, input logic fl,
                              input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                              input logic [31:0] a_d0, input logic a_b0, input logic [31:0] a_d1,
                              input logic a_b1, input logic [31:0] b_d0, input logic [5:0] cnt);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ia = ia; v.fl = fl;
    v.r0 = r0; v.r1 = r1; v.r2 = r2;
    v.a_d0 = a_d0; v.a_b0 = a_b0; v.a_d1 = a_d1; v.a_b1 = a_b1; v.b_d0 = b_d0; v.cnt = cnt;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
    iss_en = v.ie; iss_addr = v.ia; flush = v.fl;
    ra[0] = v.r0; ra[1] = v.r1; ra[2] = v.r2;
    exp_q.push_back(m_predict(0, 1'b1, 2));
    exp_q.push_back(m_predict(0, 1'b0, 2));
    exp_q.push_back(m_predict(1, 1'b1, 3));
  endtask

  task automatic pop_check(input string where);
    if (exp_q.size() < 3) begin
      checks++; errors++;
      $display("FAIL %s queue underflow size=%0d required=3", where, exp_q.size());
    end else begin
      chk({where, " a"}, act_a(), exp_q.pop_front());
      chk({where, " b"}, act_b(), exp_q.pop_front());
      chk({where, " c"}, act_c(), exp_q.pop_front());
    end
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    if (rst_n) begin
      m_edge(0);
      m_edge(1);
    end
    #1;
  endtask

  vec_t tbl [14];
  vec_t idle;

  initial begin
    // we wa wd            ie ia fl  r0 r1 r2 | a_d0 a_b0 a_d1 a_b1 b_d0 cnt
    tbl[0]  = mk(1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0,
                 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 6'd0);
    tbl[1]  = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0,
                 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 6'd0);
    tbl[2]  = mk(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 5'd7, 5'd7, 5'd7,
                 32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 1'b0, 32'h0, 6'd0);
    tbl[3]  = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd7, 5'd7,
                 32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 6'd0);
    tbl[4]  = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd3, 5'd3,
                 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 6'd0);
    tbl[5]  = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd3, 5'd4, 5'd4,
                 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 6'd1);
    tbl[6]  = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd4, 5'd4,
                 32'h0, 1'b1, 32'h0, 1'b1, 32'h0, 6'd2);
    tbl[7]  = mk(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 1'b0, 5'd3, 5'd4, 5'd3,
                 32'h33, 1'b0, 32'h0, 1'b1, 32'h0, 6'd2);
    tbl[8]  = mk(1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 1'b0, 5'd3, 5'd4, 5'd4,
                 32'h33, 1'b0, 32'h44, 1'b1, 32'h33, 6'd1);
    tbl[9]  = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd4, 5'd3, 5'd4,
                 32'h44, 1'b1, 32'h33, 1'b0, 32'h44, 6'd1);
    tbl[10] = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd4, 5'd3, 5'd3,
                 32'h44, 1'b1, 32'h33, 1'b0, 32'h44, 6'd1);
    tbl[11] = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd3, 5'd9, 5'd9,
                 32'h33, 1'b1, 32'h0, 1'b0, 32'h33, 6'd2);
    tbl[12] = mk(1'b1, 5'd3, 32'h55, 1'b1, 5'd10, 1'b1, 5'd9, 5'd3, 5'd10,
                 32'h0, 1'b1, 32'h55, 1'b0, 32'h0, 6'd3);
    tbl[13] = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd10, 5'd10,
                 32'h55, 1'b0, 32'h0, 1'b0, 32'h55, 6'd0);
    idle = tbl[1];

    // ---- reset: clear from mid-cycle, without an edge ----
    m_reset();
    rst_n = 1'b0;
    apply(idle);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;

    apply(mk(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd6, 1'b0, 5'd5, 5'd5, 5'd5,
             32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 6'd0));
    @(negedge clk) pop_check("rst_pre_w");
    finish_cycle();
    apply(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd6, 5'd5,
             32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 6'd0));
    @(negedge clk) pop_check("rst_pre_r");
    chk("rst_pre_cnt", 128'(if_a.busy_cnt), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk("rst_a_data", 128'(if_a.rd_data[31:0]), 128'd0);
    chk("rst_a_cnt", 128'(if_a.busy_cnt), 128'd0);
    chk("rst_a_busy", 128'(if_a.rd_busy), 128'd0);
    chk("rst_b_data", 128'(if_b.rd_data[31:0]), 128'd0);
    chk("rst_c_data", 128'(if_c.rd_data[31:0]), 128'd0);
    chk("rst_c_cnt", 128'(if_c.busy_cnt), 128'd0);
    finish_cycle();
    @(negedge clk);
    chk("rst_hold_data", 128'(if_a.rd_data[31:0]), 128'd0);
    rst_n = 1'b1;
    @(posedge clk) #1;

    // ---- table-driven directed vectors ----
    for (int i = 0; i < 14; i++) begin
      apply(tbl[i]);
      @(negedge clk);
      pop_check($sformatf("v%0d", i));
      chk($sformatf("v%0d a_d0", i), 128'(if_a.rd_data[31:0]), 128'(tbl[i].a_d0));
      chk($sformatf("v%0d a_b0", i), 128'(if_a.rd_busy[0]), 128'(tbl[i].a_b0));
      chk($sformatf("v%0d a_d1", i), 128'(if_a.rd_data[63:32]), 128'(tbl[i].a_d1));
      chk($sformatf("v%0d a_b1", i), 128'(if_a.rd_busy[1]), 128'(tbl[i].a_b1));
      chk($sformatf("v%0d b_d0", i), 128'(if_b.rd_data[31:0]), 128'(tbl[i].b_d0));
      chk($sformatf("v%0d cnt", i), 128'(if_a.busy_cnt), 128'(tbl[i].cnt));
      finish_cycle();
    end

    // ---- 24-register, 3-port instance: top register and out-of-range address ----
    apply(mk(1'b1, 5'd23, 32'hCAFE0023, 1'b0, 5'd0, 1'b0, 5'd23, 5'd23, 5'd23,
             32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 6'd0));
    @(negedge clk) pop_check("c_r23_byp");
    chk("c_r23_byp_data", 128'(if_c.rd_data), 128'({3{32'hCAFE0023}}));
    finish_cycle();
    apply(mk(1'b1, 5'd30, 32'hBAD0BAD0, 1'b1, 5'd30, 1'b0, 5'd23, 5'd23, 5'd23,
             32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 6'd0));
    @(negedge clk) pop_check("c_r30_w");
    chk("c_r23_data", 128'(if_c.rd_data), 128'({3{32'hCAFE0023}}));
    finish_cycle();
    apply(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd30, 5'd23, 5'd30,
             32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 6'd0));
    @(negedge clk) pop_check("c_r30_r");
    chk("c_r30_data", 128'(if_c.rd_data[31:0]), 128'd0);
    chk("c_r30_busy", 128'(if_c.rd_busy), 128'd0);
    chk("c_r30_cnt", 128'(if_c.busy_cnt), 128'd0);
    chk("a_r30_busy", 128'(if_a.rd_busy[0]), 128'd1);
    finish_cycle();

    // ---- random traffic against the model ----
    for (int n = 0; n < 400; n++) begin
      vec_t v;
      v = idle;
      v.we = 1'($urandom_range(0, 1));
      v.wa = 5'($urandom_range(0, 31));
      v.wd = $urandom();
      v.ie = 1'($urandom_range(0, 1));
      v.ia = 5'($urandom_range(0, 31));
      v.fl = ($urandom_range(0, 15) == 0);
      v.r0 = 5'($urandom_range(0, 31));
      v.r1 = ($urandom_range(0, 3) == 0) ? v.wa : 5'($urandom_range(0, 31));
      v.r2 = ($urandom_range(0, 3) == 0) ? v.ia : 5'($urandom_range(0, 31));
      apply(v);
      @(negedge clk);
      pop_check($sformatf("rnd%0d", n));
      finish_cycle();
    end

    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
